// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: takes a WIDTH-bit word over valid/ready and shifts it
// out MSB-first on ser_out, then inserts GAP idle zero bits before the next word.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam bit NO_GAP = (GAP == 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             ser_out_reg, ser_out_next;
  logic             transfer;
  logic             load;

  always_comb begin
    data_ready = 1'b0;
    case (state_reg)
      S_IDLE:  data_ready = 1'b1;
      S_SHIFT: data_ready = NO_GAP && (bit_cnt_reg == LAST_BIT);
      S_GAP:   data_ready = (gap_cnt_reg == LAST_GAP);
      default: data_ready = 1'b0;
    endcase
  end

  assign transfer   = data_valid && data_ready;
  assign ser_out    = ser_out_reg;
  assign ser_active = (state_reg == S_SHIFT);
  assign word_done  = (state_reg == S_SHIFT) && (bit_cnt_reg == LAST_BIT);

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    shift_next   = shift_reg;
    ser_out_next = 1'b0;
    load         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        load = transfer;
      end
      S_SHIFT: begin
        if (bit_cnt_reg != LAST_BIT) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          ser_out_next = shift_reg[WIDTH-1];
          shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
        end else if (!NO_GAP) begin
          state_next   = S_GAP;
          bit_cnt_next = '0;
          gap_cnt_next = '0;
        end else if (transfer) begin
          load = 1'b1;
        end else begin
          state_next   = S_IDLE;
          bit_cnt_next = '0;
          gap_cnt_next = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg != LAST_GAP) begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end else if (transfer) begin
          load = 1'b1;
        end else begin
          state_next   = S_IDLE;
          bit_cnt_next = '0;
          gap_cnt_next = '0;
        end
      end
      default: begin
        state_next   = S_IDLE;
        bit_cnt_next = '0;
        gap_cnt_next = '0;
      end
    endcase
    // The MSB goes straight to ser_out; the rest waits in the shift register.
    if (load) begin
      state_next   = S_SHIFT;
      bit_cnt_next = '0;
      gap_cnt_next = '0;
      ser_out_next = data_in[WIDTH-1];
      shift_next   = {data_in[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      shift_reg   <= '0;
      ser_out_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      shift_reg   <= shift_next;
      ser_out_reg <= ser_out_next;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one GAP=2 instance and one GAP=0 instance,
// per-cycle expectations queued when stimulus is driven and checked after each edge.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_din = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_ser, a_act, a_done;
  logic [7:0] b_din = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_ser, b_act, b_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Expected {ser_out, ser_active, word_done, data_ready} for one cycle.
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .data_valid(a_valid),
    .data_ready(a_ready), .ser_out(a_ser), .ser_active(a_act), .word_done(a_done)
  );

  bit_serializer #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_valid(b_valid),
    .data_ready(b_ready), .ser_out(b_ser), .ser_active(b_act), .word_done(b_done)
  );

  task automatic push_word(input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({w[7-i], 1'b1, (i == 7), ((i == 7) && (gap == 0))});
    for (int j = 0; j < gap; j++)
      exp_q.push_back({3'b000, (j == gap - 1)});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0001);
  endtask

  task automatic check_cycle(input string tag, input bit use_b);
    logic [3:0] obs;
    logic [3:0] expv;
    @(posedge clk);
    #1;
    obs = use_b ? {b_ser, b_act, b_done, b_ready} : {a_ser, a_act, a_done, a_ready};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed %b", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s observed(ser,act,done,rdy)=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_n(input string tag, input bit use_b, input int n);
    for (int i = 0; i < n; i++) check_cycle(tag, use_b);
  endtask

  initial begin
    // Reset held with a word offered: nothing may be accepted.
    rst = 1'b0; a_valid = 1'b1; a_din = 8'hFF; b_valid = 1'b1; b_din = 8'hFF;
    push_idle(3);
    check_n("reset_a", 1'b0, 3);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    push_idle(1);
    check_cycle("post_reset_idle", 1'b0);

    // Single word 0xB6, then GAP zeros and an IDLE cycle.
    a_din = 8'hB6; a_valid = 1'b1;
    push_word(8'hB6, 2);
    push_idle(1);
    check_cycle("single_b6", 1'b0);
    a_valid = 1'b0; a_din = 8'h00;
    check_n("single_b6", 1'b0, 10);

    // Back-to-back with valid held: second accept in the last GAP cycle.
    a_din = 8'hFF; a_valid = 1'b1;
    push_word(8'hFF, 2);
    push_word(8'h00, 2);
    push_idle(1);
    check_cycle("b2b_ff", 1'b0);
    a_din = 8'h00;
    check_n("b2b_ff", 1'b0, 9);
    check_cycle("b2b_00", 1'b0);
    a_valid = 1'b0;
    check_n("b2b_00", 1'b0, 10);

    // Input stability: data_in changes after the accept must not matter.
    a_din = 8'hA5; a_valid = 1'b1;
    push_word(8'hA5, 2);
    push_idle(1);
    check_cycle("stable_a5", 1'b0);
    a_valid = 1'b0; a_din = 8'h00;
    check_n("stable_a5", 1'b0, 10);

    // Reset during bit 4 of 0xFF: remaining bits are discarded.
    a_din = 8'hFF; a_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1100);
    check_cycle("midreset_bits", 1'b0);
    a_valid = 1'b0;
    check_n("midreset_bits", 1'b0, 3);
    rst = 1'b0;
    push_idle(1);
    check_cycle("midreset_rst", 1'b0);
    rst = 1'b1;
    push_idle(3);
    check_n("midreset_idle", 1'b0, 3);

    // GAP=0 instance: 0xAA then 0x55 as 16 contiguous bits.
    b_din = 8'hAA; b_valid = 1'b1;
    push_word(8'hAA, 0);
    push_word(8'h55, 0);
    push_idle(2);
    check_cycle("gap0_aa", 1'b1);
    b_din = 8'h55;
    check_n("gap0_aa", 1'b1, 7);
    check_cycle("gap0_55", 1'b1);
    b_valid = 1'b0; b_din = 8'h00;
    check_n("gap0_55", 1'b1, 9);

    total_cnt++;
    assert (exp_q.size() == 0) pass_cnt++;
    else $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the sequence-detector FSM. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on ser_out. ser_out drives the detector's serial `in` input. A programmable run of idle zero bits (GAP) follows each word, so consecutive words reach the detector separated by a known 0-run.

Parameters:
WIDTH, 8, word width in bits; legal values WIDTH >= 2.
GAP, 2, number of idle cycles (ser_out = 0) inserted after each word; legal values GAP >= 0.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
data_in  input  WIDTH  parallel word; sampled only on an accepting edge.
data_valid  input  1  upstream has a word on data_in.
data_ready  output  1  block can accept a word this cycle.
ser_out  output  1  registered serial bit stream, MSB first.
ser_active  output  1  high while ser_out carries a word bit.
word_done  output  1  one-cycle pulse while the LSB is on ser_out.

Behaviour:
- Reset: on any rising edge with rst = 0, all state returns to reset values. Any word in flight is discarded.
- Reset values: state IDLE, ser_out = 0, ser_active = 0, word_done = 0, bit_cnt = 0, gap_cnt = 0. data_ready = 1 in the first cycle after reset.
- States:
  - IDLE: ser_out = 0.
  - SHIFT: WIDTH cycles of word bits.
  - GAP: GAP cycles of ser_out = 0.
- Transfer rule: a word transfers on a rising edge where data_valid = 1 and data_ready = 1. At that edge data_in is loaded into the shift register, and later data_in changes are ignored.
- data_ready is combinational from state and counters. It is 1 in exactly these cases:
  - state IDLE;
  - state GAP with gap_cnt = GAP-1;
  - state SHIFT with bit_cnt = WIDTH-1 and GAP = 0.
  In every other case data_ready = 0.
- Latency: for a transfer at edge e0, in the cycle after edge e0+i (i = 0..WIDTH-1):
  - ser_out = word[WIDTH-1-i];
  - ser_active = 1;
  - bit_cnt = i.
- word_done = 1 only in the cycle where bit_cnt = WIDTH-1.
- Transitions:
  - IDLE -> SHIFT on transfer.
  - SHIFT (last bit) -> GAP if GAP > 0.
  - SHIFT (last bit) -> SHIFT, with the new word's MSB, if GAP = 0 and a transfer occurs.
  - SHIFT (last bit) -> IDLE if GAP = 0 and no transfer.
  - GAP (gap_cnt = GAP-1) -> SHIFT on transfer, otherwise -> IDLE.
  - GAP with gap_cnt < GAP-1: gap_cnt increments.
- Back-to-back: with data_valid held high, words stream with exactly GAP zero bits between them and no IDLE cycle.
- data_valid low in IDLE: block stays IDLE, ser_out = 0 indefinitely.
- GAP cycles: ser_active = 0, word_done = 0, ser_out = 0.
- Counters: bit_cnt is $clog2(WIDTH) bits and gap_cnt is max(1, $clog2(GAP+1)) bits. Both clear to 0 on every state entry. Neither wraps outside its state.
- Simultaneous rst = 0 and transfer: reset wins; no word is accepted.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with data_valid = 1 and data_in = 8'hFF -> ser_out = 0, ser_active = 0, word_done = 0, data_ready = 1, nothing accepted.
- Single word: send 8'hB6 -> cycles 1..8 after the accept give ser_out = 1,0,1,1,0,1,1,0, ser_active = 1, word_done only in cycle 8. Cycles 9..10 give ser_out = 0 with data_ready low in cycle 9 and high in cycle 10. Cycle 11 is IDLE.
- Back-to-back with data_valid held: send 8'hFF then 8'h00 -> 8 ones, exactly 2 zeros, then 8 zeros. Second accept occurs in the last GAP cycle. When ser_out feeds the detector, the detector's out is high for exactly one cycle.
- Input stability: send 8'hA5, then change data_in to 8'h00 in cycle 2 -> ser_out still gives 1,0,1,0,0,1,0,1.
- Reset mid-word: drive rst = 0 during bit 4 of 8'hFF -> next cycle ser_out = 0, ser_active = 0, state IDLE. The remaining bits never appear.
- GAP = 0 build: stream 8'hAA then 8'h55 -> 16 contiguous bits 1010101001010101, word_done in cycles 8 and 16, data_ready high in cycle 8.
